// File: rtl/cr_xp10_decomp_lz_ser_pkg.sv
// Shared types for the XP10 LZ lane serialiser: symbol bus, output item and error codes.
package cr_xp10_decomp_lz_ser_pkg;

  typedef enum logic [7:0] {
    NO_ERRORS            = 8'h00,
    HD_MTF_BAD_SYMBOL    = 8'h01,
    HD_LZ_EMPTY_WORD     = 8'h21,
    HD_LZ_BAD_LANE_COUNT = 8'h22,
    HD_LZ_ZERO_OFFSET    = 8'h23
  } zipline_error_e;

  typedef enum logic [1:0] {
    LIT  = 2'd0,
    BREF = 2'd1,
    EOB  = 2'd2,
    TRL  = 2'd3
  } lz_item_kind_e;

  typedef struct packed {
    logic [3:0]      framing;
    logic            backref;
    logic [1:0]      backref_lane;
    logic [7:0]      offset_msb;
    logic [3:0][7:0] data;
  } lz_symbol_bus_t;

  typedef struct packed {
    lz_item_kind_e  kind;
    logic [7:0]     lit_byte;
    logic [15:0]    offset;
    zipline_error_e errcode;
  } lz_item_t;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [3:0] FRAMING_TRAILER = 4'hf;

  // Position of the lowest pending item; bit 4 is the EOB slot.
  function automatic logic [2:0] first_set(input logic [4:0] m);
    first_set = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (m[i]) first_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/cr_xp10_decomp_lz_ser_cnt.sv
// Saturating per-frame event counter with synchronous clear (clear wins over increment).
module cr_xp10_decomp_lz_ser_cnt #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cr_xp10_decomp_lz_ser.sv
// Serialises up to four-lane LZ symbol words into one item per cycle, with frame stats and error folding.
module cr_xp10_decomp_lz_ser
  import cr_xp10_decomp_lz_ser_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mtf_lz_dp_valid,
  input  lz_symbol_bus_t   mtf_lz_dp_bus,
  output logic             lz_mtf_dp_ready,
  output logic             ser_lz_valid,
  output lz_item_t         ser_lz_item,
  input  logic             lz_ser_ready,
  output logic             ser_stat_valid,
  output logic [CNT_W-1:0] ser_stat_lit,
  output logic [CNT_W-1:0] ser_stat_bref
);

  logic [0:0]       state_q, state_d;
  lz_symbol_bus_t   word_q, word_d;
  logic [4:0]       mask_q, mask_d;
  zipline_error_e   err_q, err_d;
  logic             stat_valid_q, stat_valid_d;
  logic [CNT_W-1:0] stat_lit_q, stat_lit_d, stat_bref_q, stat_bref_d;
  logic [CNT_W-1:0] lit_cnt, bref_cnt;

  logic [2:0]       n_lanes, cur_idx;
  logic [15:0]      new_off;
  logic [4:0]       new_mask;
  zipline_error_e   new_err;
  lz_item_t         item;
  logic             last_item, out_hs, accept, trl_hs;

  // Pending-item mask for an incoming word; zero-offset backrefs are never scheduled.
  always_comb begin
    n_lanes  = (mtf_lz_dp_bus.framing[2:0] > 3'd4) ? 3'd4 : mtf_lz_dp_bus.framing[2:0];
    new_off  = {mtf_lz_dp_bus.offset_msb, mtf_lz_dp_bus.data[mtf_lz_dp_bus.backref_lane]};
    new_mask = '0;
    for (int i = 0; i < 4; i++) begin
      new_mask[i] = (3'(i) < n_lanes);
    end
    if (mtf_lz_dp_bus.backref && (new_off == 16'd0)) begin
      new_mask[mtf_lz_dp_bus.backref_lane] = 1'b0;
    end
    new_mask[4] = mtf_lz_dp_bus.framing[3];
    new_err     = NO_ERRORS;
    if (mtf_lz_dp_bus.framing == FRAMING_TRAILER) begin
      new_mask = 5'b00001;
    end else if (mtf_lz_dp_bus.framing == 4'h0) begin
      new_err = HD_LZ_EMPTY_WORD;
    end else if (mtf_lz_dp_bus.framing[2:0] > 3'd4) begin
      new_err = HD_LZ_BAD_LANE_COUNT;
    end else if (mtf_lz_dp_bus.backref && ({1'b0, mtf_lz_dp_bus.backref_lane} < n_lanes)
                 && (new_off == 16'd0)) begin
      new_err = HD_LZ_ZERO_OFFSET;
    end
  end

  always_comb begin
    cur_idx   = first_set(mask_q);
    last_item = ((mask_q & (mask_q - 5'd1)) == 5'd0);
    item      = '0;
    if (word_q.framing == FRAMING_TRAILER) begin
      item.kind    = TRL;
      item.errcode = zipline_error_e'(word_q.data[0]);
      if ((item.errcode == NO_ERRORS) && (err_q != NO_ERRORS)) item.errcode = err_q;
    end else if (cur_idx == 3'd4) begin
      item.kind = EOB;
    end else if (word_q.backref && (word_q.backref_lane == cur_idx[1:0])) begin
      item.kind   = BREF;
      item.offset = {word_q.offset_msb, word_q.data[cur_idx[1:0]]};
    end else begin
      item.kind     = LIT;
      item.lit_byte = word_q.data[cur_idx[1:0]];
    end
  end

  assign ser_lz_valid    = (state_q == ST_DRAIN);
  assign ser_lz_item     = item;
  assign out_hs          = ser_lz_valid && lz_ser_ready;
  assign lz_mtf_dp_ready = (state_q == ST_EMPTY) || (out_hs && last_item);
  assign accept          = mtf_lz_dp_valid && lz_mtf_dp_ready;
  assign trl_hs          = out_hs && (item.kind == TRL);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    mask_d  = mask_q;
    if (accept) begin
      word_d  = mtf_lz_dp_bus;
      mask_d  = new_mask;
      state_d = (new_mask != 5'd0) ? ST_DRAIN : ST_EMPTY;
    end else if (out_hs) begin
      mask_d = mask_q & ~(5'd1 << cur_idx);
      if (last_item) state_d = ST_EMPTY;
    end
    // The first error of a frame sticks until its trailer leaves.
    err_d = trl_hs ? NO_ERRORS : err_q;
    if (accept && (err_d == NO_ERRORS)) err_d = new_err;
    stat_valid_d = trl_hs;
    stat_lit_d   = trl_hs ? lit_cnt  : stat_lit_q;
    stat_bref_d  = trl_hs ? bref_cnt : stat_bref_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      word_q       <= '0;
      mask_q       <= '0;
      err_q        <= NO_ERRORS;
      stat_valid_q <= 1'b0;
      stat_lit_q   <= '0;
      stat_bref_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      mask_q       <= mask_d;
      err_q        <= err_d;
      stat_valid_q <= stat_valid_d;
      stat_lit_q   <= stat_lit_d;
      stat_bref_q  <= stat_bref_d;
    end
  end

  cr_xp10_decomp_lz_ser_cnt #(.W(CNT_W)) u_lit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_hs && (item.kind == LIT)),
    .clr   (trl_hs),
    .cnt   (lit_cnt)
  );

  cr_xp10_decomp_lz_ser_cnt #(.W(CNT_W)) u_bref_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_hs && (item.kind == BREF)),
    .clr   (trl_hs),
    .cnt   (bref_cnt)
  );

  assign ser_stat_valid = stat_valid_q;
  assign ser_stat_lit   = stat_lit_q;
  assign ser_stat_bref  = stat_bref_q;

endmodule

// File: doc/cr_xp10_decomp_lz_ser.md
# cr_xp10_decomp_lz_ser

Lane serialiser between the MTF stage and the LZ history engine in the XP10 decompressor. Accepts up to four-lane `lz_symbol_bus_t` words, already carrying resolved backref offsets, and emits one literal, backref, end-of-block or trailer item per cycle. Keeps per-frame literal and backref counts and reports them on the trailer. Folds locally detected framing errors into the trailer error code.

## Interface
- `CNT_W`, default 24: width of the per-frame literal and backref counters.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `mtf_lz_dp_valid` in 1: input word valid.
- `mtf_lz_dp_bus` in `$bits(lz_symbol_bus_t)`: input word.
- `lz_mtf_dp_ready` out 1: input word accepted when high together with valid.
- `ser_lz_valid` out 1: output item valid.
- `ser_lz_item` out `$bits(lz_item_t)`: output item.
- `lz_ser_ready` in 1: downstream ready.
- `ser_stat_valid` out 1: one-cycle strobe that accompanies a completed trailer handshake.
- `ser_stat_lit` out `CNT_W`: literals in the frame.
- `ser_stat_bref` out `CNT_W`: backrefs in the frame.

## Operation
- Input word classes:
  - `framing == 4'hf`: trailer. Data bytes `{data3..data0}` carry `zipline_error_e` in their low bits.
  - Otherwise `framing[2:0]` is the lane count n, where 0 ≤ n ≤ 4, and `framing[3]` marks EOB after the last lane.
  - With `backref` set, lane `backref_lane` is a backref with offset `{offset_msb, data[backref_lane]}`. Every other lane in 0..n-1 is a literal.
- Item kinds, emitted in this order per word: lanes 0..n-1, then EOB if `framing[3]` is set.
  - LIT: byte.
  - BREF: 16-bit offset.
  - EOB.
  - TRL: errcode.
- Word buffer: one registered input word plus a 3-bit item index.
  - `lz_mtf_dp_ready` = buffer empty, or the last item of the buffered word is handshaking this cycle. New words therefore load with no bubble.
- States: EMPTY, DRAIN.
  - EMPTY → DRAIN on accept.
  - DRAIN → EMPTY when the last item handshakes and no new word arrives.
  - DRAIN → DRAIN when the last item handshakes and a new word loads in the same cycle.
- Words with no items (`framing == 0`) are accepted and dropped. They also set the latched error `HD_LZ_EMPTY_WORD`.
- `framing[2:0] > 4`:
  - Latch `HD_LZ_BAD_LANE_COUNT`.
  - Treat the word as having 4 lanes.
- BREF with offset 0:
  - Latch `HD_LZ_ZERO_OFFSET`.
  - Drop the item without emitting it; it occupies no output cycle.
- Error latch:
  - Only the first error is kept until the next trailer.
  - On TRL emit: if the incoming errcode is `NO_ERRORS` and the latch is not, the latched code replaces it.
  - The latch clears when the trailer handshakes.
- Counters `lit_cnt` and `bref_cnt`:
  - Increment on each LIT or BREF output handshake.
  - Saturate at all ones.
  - On the TRL handshake: drive their values, including the current cycle's increments (none, since TRL is alone), on `ser_stat_*`, pulse `ser_stat_valid`, and clear both counters to 0.
- Downstream stall: while `ser_lz_valid` is high and `lz_ser_ready` is low, item and index hold stable and `lz_mtf_dp_ready` stays low.

## Timing
- Reset values: `ser_lz_valid` = 0, `lz_mtf_dp_ready` = 1 (buffer empty), `ser_stat_valid` = 0, stats = 0, error latch = `NO_ERRORS`, state EMPTY.
- Latency: an input handshake in cycle t gives the first item valid in cycle t+1.
- Throughput: one item per cycle sustained.
- Output is registered. `lz_mtf_dp_ready` is combinational from buffer state and `lz_ser_ready`.
- `ser_stat_*` is registered: it is valid in the cycle after the TRL handshake, for one cycle.
- Reset mid-word: the buffered word and counters are discarded.

## Structure
- `cr_xp10_decompPKG` gains:
  - `lz_item_kind_e` {LIT, BREF, EOB, TRL}.
  - `lz_item_t` {kind, byte[7:0], offset[15:0], errcode}.
- `cr_error_codes` gains `HD_LZ_EMPTY_WORD`, `HD_LZ_BAD_LANE_COUNT` and `HD_LZ_ZERO_OFFSET`.
- One sub-module: `cr_xp10_decomp_lz_ser_cnt`, a saturating clearable counter instanced twice.

## Test plan
- Word with framing 4, lanes 0x41/0x42/0x43/0x44 and no backref, downstream always ready → four LIT items 0x41..0x44 in consecutive cycles with no bubble into the next word.
- Word with framing 4'hB, backref lane 1, offset_msb 0x01, data1 0x20 → LIT, BREF 0x0120, LIT, then EOB: four items.
- Stall `lz_ser_ready` low for 5 cycles mid-word → item held stable, no input accepted, sequence resumes intact.
- Frame of 3 LIT and 1 BREF, then trailer with `NO_ERRORS` → TRL errcode `NO_ERRORS`; next cycle `ser_stat_valid` = 1, lit = 3, bref = 1; counters reset to 0.
- BREF with offset 0, then trailer with `NO_ERRORS` → BREF not emitted; TRL errcode `HD_LZ_ZERO_OFFSET`.
- Trailer carrying a nonzero code while the latch holds `HD_LZ_BAD_LANE_COUNT` → trailer code passes unchanged; latch cleared; `CNT_W` = 4 with 20 literals → lit reports 15.
